// File: rtl/ins_mem_pkg.sv
// ins_mem_pkg: shared types and constants for the multi-port instruction memory.
//   state_t       : loader/run state machine encoding (IDLE, LOAD, DONE, RUN)
//   NOP, ENDOP    : opcode constants; ENDOP is the word returned on an out-of-range fetch
//   addr_in_range : true when an address indexes a valid word of a DEPTH-word array
package ins_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        RUN  = 2'd3
    } state_t;

    localparam logic [15:0] NOP   = 16'd4;
    localparam logic [15:0] ENDOP = 16'd44;

    // Callers zero-extend their address to 32 bits so one helper serves every width.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/ins_mem_loader.sv
// ins_mem_loader: burst program loader and run gate for the instruction memory.
//   Inputs : clk, rst_n, burst handshake (ld_start/ld_base/ld_len/ld_valid/ld_data),
//            host direct write (im_write_en/im_addr/im_input_data)
//   Outputs: ld_ready, ld_done, ld_err, mem_ready (all registered), current state,
//            and the single write port (wr_en/wr_idx/wr_data) into the storage array.
module ins_mem_loader
    import ins_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 128,
    parameter int IDX_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W-1:0] ld_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              im_write_en,
    input  logic [ADDR_W-1:0] im_addr,
    input  logic [DATA_W-1:0] im_input_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              ld_err,
    output logic              mem_ready,
    output state_t            state,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_idx,
    output logic [DATA_W-1:0] wr_data
);

    state_t            state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W-1:0] cnt_r;
    logic              ld_ready_r;
    logic              ld_done_r;
    logic              ld_err_r;
    logic              mem_ready_r;
    logic              beat_s;
    logic              ptr_ok_s;
    logic              wr_en_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic [DATA_W-1:0] wr_data_s;

    // ld_ready_r is only ever high in LOAD, so it alone qualifies an accepted beat.
    assign beat_s   = ld_valid && ld_ready_r;
    assign ptr_ok_s = addr_in_range(32'(ptr_r), DEPTH);

    // Loader state machine with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ptr_r       <= {ADDR_W{1'b0}};
            cnt_r       <= {ADDR_W{1'b0}};
            ld_ready_r  <= 1'b0;
            ld_done_r   <= 1'b0;
            ld_err_r    <= 1'b0;
            mem_ready_r <= 1'b0;
        end else begin
            ld_done_r <= 1'b0;
            case (state_r)
                IDLE, RUN: begin
                    if (ld_start) begin
                        ptr_r       <= ld_base;
                        cnt_r       <= ld_len;
                        ld_err_r    <= 1'b0;
                        mem_ready_r <= 1'b0;
                        if (ld_len == {ADDR_W{1'b0}}) begin
                            state_r   <= DONE;
                            ld_done_r <= 1'b1;
                        end else begin
                            state_r    <= LOAD;
                            ld_ready_r <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (beat_s) begin
                        // Out-of-range beats still count toward the burst length.
                        ptr_r <= ptr_r + ADDR_W'(1'b1);
                        cnt_r <= cnt_r - ADDR_W'(1'b1);
                        if (!ptr_ok_s) begin
                            ld_err_r <= 1'b1;
                        end
                        if (cnt_r == ADDR_W'(1'b1)) begin
                            state_r    <= DONE;
                            ld_ready_r <= 1'b0;
                            ld_done_r  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_r     <= RUN;
                    mem_ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= IDLE;
                    ld_ready_r  <= 1'b0;
                    mem_ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Write-port mux: burst beats own the port in LOAD, host writes in IDLE/RUN.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = {IDX_W{1'b0}};
        wr_data_s = {DATA_W{1'b0}};
        if (state_r == LOAD) begin
            wr_en_s   = beat_s && ptr_ok_s;
            wr_idx_s  = ptr_r[IDX_W-1:0];
            wr_data_s = ld_data;
        end else if ((state_r == IDLE) || (state_r == RUN)) begin
            wr_en_s   = im_write_en && addr_in_range(32'(im_addr), DEPTH);
            wr_idx_s  = im_addr[IDX_W-1:0];
            wr_data_s = im_input_data;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    assign ld_ready  = ld_ready_r;
    assign ld_done   = ld_done_r;
    assign ld_err    = ld_err_r;
    assign mem_ready = mem_ready_r;
    assign state     = state_r;
    assign wr_en     = wr_en_s;
    assign wr_idx    = wr_idx_s;
    assign wr_data   = wr_data_s;

endmodule

// File: rtl/ins_memory_mp.sv
// ins_memory_mp: multi-port instruction memory for the N-core matmul processor.
//   Fetch  : rd_en/rd_addr per port -> rd_data/rd_valid/rd_oob one cycle later (RUN only)
//   Host   : im_write_en/im_addr/im_input_data single-word write (IDLE/RUN only)
//   Loader : ld_start/ld_base/ld_len/ld_valid/ld_data with ld_ready/ld_done/ld_err
//   Gate   : mem_ready high once a program has been loaded
// Storage is read-before-write: a fetch and a write to one address in the same
// cycle return the old word.
module ins_memory_mp
    import ins_mem_pkg::*;
#(
    parameter int                NUM_PORTS = 4,
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter int                DEPTH     = 128,
    parameter logic [DATA_W-1:0] OOB_WORD  = DATA_W'(ENDOP)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          rd_en,
    input  logic [NUM_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [NUM_PORTS*DATA_W-1:0]   rd_data,
    output logic [NUM_PORTS-1:0]          rd_valid,
    output logic [NUM_PORTS-1:0]          rd_oob,
    input  logic                          im_write_en,
    input  logic [ADDR_W-1:0]             im_addr,
    input  logic [DATA_W-1:0]             im_input_data,
    input  logic                          ld_start,
    input  logic [ADDR_W-1:0]             ld_base,
    input  logic [ADDR_W-1:0]             ld_len,
    input  logic                          ld_valid,
    input  logic [DATA_W-1:0]             ld_data,
    output logic                          ld_ready,
    output logic                          ld_done,
    output logic                          ld_err,
    output logic                          mem_ready
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_r [DEPTH];
    state_t            state_s;
    logic              wr_en_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic [DATA_W-1:0] wr_data_s;

    ins_mem_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_loader (
        .clk           (clk),
        .rst_n         (rst_n),
        .ld_start      (ld_start),
        .ld_base       (ld_base),
        .ld_len        (ld_len),
        .ld_valid      (ld_valid),
        .ld_data       (ld_data),
        .im_write_en   (im_write_en),
        .im_addr       (im_addr),
        .im_input_data (im_input_data),
        .ld_ready      (ld_ready),
        .ld_done       (ld_done),
        .ld_err        (ld_err),
        .mem_ready     (mem_ready),
        .state         (state_s),
        .wr_en         (wr_en_s),
        .wr_idx        (wr_idx_s),
        .wr_data       (wr_data_s)
    );

    // Storage write; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_idx_s] <= wr_data_s;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [ADDR_W-1:0] addr_s;
        logic [DATA_W-1:0] data_r;
        logic              valid_r;
        logic              oob_r;

        assign addr_s = rd_addr[p*ADDR_W +: ADDR_W];

        // Fetch register: data and oob hold their last value when no fetch is issued.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_r  <= {DATA_W{1'b0}};
                valid_r <= 1'b0;
                oob_r   <= 1'b0;
            end else if (rd_en[p] && (state_s == RUN)) begin
                valid_r <= 1'b1;
                if (addr_in_range(32'(addr_s), DEPTH)) begin
                    data_r <= mem_r[addr_s[IDX_W-1:0]];
                    oob_r  <= 1'b0;
                end else begin
                    data_r <= OOB_WORD;
                    oob_r  <= 1'b1;
                end
            end else begin
                valid_r <= 1'b0;
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = data_r;
        assign rd_valid[p]                 = valid_r;
        assign rd_oob[p]                   = oob_r;
    end

endmodule

// File: tb/tb_ins_memory_mp.sv
// tb_ins_memory_mp: directed, table-driven bench for ins_memory_mp (4 ports, 128 words).
module tb_ins_memory_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  rd_en;
    logic [63:0] rd_addr;
    logic [63:0] rd_data;
    logic [3:0]  rd_valid;
    logic [3:0]  rd_oob;
    logic        im_write_en;
    logic [15:0] im_addr;
    logic [15:0] im_input_data;
    logic        ld_start;
    logic [15:0] ld_base;
    logic [15:0] ld_len;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic        ld_done;
    logic        ld_err;
    logic        mem_ready;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] beat_data [8];

    typedef struct packed {
        logic [3:0]  en;
        logic [63:0] addr;
        logic [63:0] data;
        logic [3:0]  valid;
        logic [3:0]  oobm;
    } vec_t;

    vec_t vecs [7];

    ins_memory_mp dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_oob        (rd_oob),
        .im_write_en   (im_write_en),
        .im_addr       (im_addr),
        .im_input_data (im_input_data),
        .ld_start      (ld_start),
        .ld_base       (ld_base),
        .ld_len        (ld_len),
        .ld_valid      (ld_valid),
        .ld_data       (ld_data),
        .ld_ready      (ld_ready),
        .ld_done       (ld_done),
        .ld_err        (ld_err),
        .mem_ready     (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One-cycle fetch on the given ports, results sampled after the edge.
    task automatic fetch(input logic [3:0] en, input logic [63:0] addr);
        rd_en   = en;
        rd_addr = addr;
        tick();
        rd_en   = 4'b0000;
    endtask

    // Burst of len beats from beat_data; gap inserts an idle cycle (with an ignored
    // ld_start) before each beat after the first; poke tries a host write during LOAD.
    task automatic burst(input logic [15:0] base, input logic [15:0] len,
                         input logic gap, input logic poke);
        ld_start = 1'b1;
        ld_base  = base;
        ld_len   = len;
        tick();
        ld_start = 1'b0;
        ld_base  = 16'd0;
        ld_len   = 16'd0;
        chk("mem_ready_drop", {63'd0, mem_ready}, 64'd0);
        if (len == 16'd0) begin
            chk("len0_done", {63'd0, ld_done}, 64'd1);
            chk("len0_ready", {63'd0, ld_ready}, 64'd0);
            tick();
            chk("len0_mem_ready", {63'd0, mem_ready}, 64'd1);
            chk("len0_done_clr", {63'd0, ld_done}, 64'd0);
        end else begin
            chk("ready_first", {63'd0, ld_ready}, 64'd1);
            for (int i = 0; i < int'(len); i++) begin
                if (gap && (i > 0)) begin
                    ld_valid = 1'b0;
                    ld_start = 1'b1;
                    tick();
                    ld_start = 1'b0;
                    chk("gap_ready", {63'd0, ld_ready}, 64'd1);
                    chk("gap_done", {63'd0, ld_done}, 64'd0);
                end
                ld_valid      = 1'b1;
                ld_data       = beat_data[i];
                im_write_en   = poke;
                im_addr       = 16'd0;
                im_input_data = 16'h00AA;
                tick();
                ld_valid    = 1'b0;
                im_write_en = 1'b0;
                if (i < int'(len) - 1) begin
                    chk("beat_ready", {63'd0, ld_ready}, 64'd1);
                    chk("beat_done", {63'd0, ld_done}, 64'd0);
                end else begin
                    chk("last_done", {63'd0, ld_done}, 64'd1);
                    chk("last_ready", {63'd0, ld_ready}, 64'd0);
                end
            end
            tick();
            chk("run_mem_ready", {63'd0, mem_ready}, 64'd1);
            chk("run_done_clr", {63'd0, ld_done}, 64'd0);
        end
    endtask

    initial begin
        // Rows follow the first load of {3,5,7} at addresses 0..2; unread ports hold.
        vecs[0] = '{en: 4'b0001, addr: {16'd0, 16'd0, 16'd0, 16'd1},
                    data: {16'h0000, 16'h0000, 16'h0000, 16'h0005}, valid: 4'b0001, oobm: 4'b0000};
        vecs[1] = '{en: 4'b1111, addr: {16'd0, 16'd2, 16'd1, 16'd0},
                    data: {16'h0003, 16'h0007, 16'h0005, 16'h0003}, valid: 4'b1111, oobm: 4'b0000};
        vecs[2] = '{en: 4'b0000, addr: {16'd9, 16'd9, 16'd9, 16'd9},
                    data: {16'h0003, 16'h0007, 16'h0005, 16'h0003}, valid: 4'b0000, oobm: 4'b0000};
        vecs[3] = '{en: 4'b0100, addr: {16'd0, 16'd200, 16'd0, 16'd0},
                    data: {16'h0003, 16'h002C, 16'h0005, 16'h0003}, valid: 4'b0100, oobm: 4'b0100};
        vecs[4] = '{en: 4'b1010, addr: {16'd2, 16'd0, 16'hFFFF, 16'd0},
                    data: {16'h0007, 16'h002C, 16'h002C, 16'h0003}, valid: 4'b1010, oobm: 4'b0010};
        vecs[5] = '{en: 4'b1111, addr: {16'd0, 16'd1, 16'd2, 16'd128},
                    data: {16'h0003, 16'h0005, 16'h0007, 16'h002C}, valid: 4'b1111, oobm: 4'b0001};
        vecs[6] = '{en: 4'b1111, addr: {16'd1, 16'd1, 16'd1, 16'd1},
                    data: {16'h0005, 16'h0005, 16'h0005, 16'h0005}, valid: 4'b1111, oobm: 4'b0000};

        rst_n = 1'b0;
        rd_en = 4'b0000; rd_addr = 64'd0;
        im_write_en = 1'b0; im_addr = 16'd0; im_input_data = 16'd0;
        ld_start = 1'b0; ld_base = 16'd0; ld_len = 16'd0; ld_valid = 1'b0; ld_data = 16'd0;
        #12;
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_rd_valid", {60'd0, rd_valid}, 64'd0);
        chk("rst_rd_oob", {60'd0, rd_oob}, 64'd0);
        chk("rst_flags", {60'd0, ld_ready, ld_done, ld_err, mem_ready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Fetch before any load is gated off.
        fetch(4'b1111, 64'd0);
        chk("pre_load_valid", {60'd0, rd_valid}, 64'd0);

        beat_data[0] = 16'h0003; beat_data[1] = 16'h0005; beat_data[2] = 16'h0007;
        burst(16'd0, 16'd3, 1'b0, 1'b0);
        chk("load1_err", {63'd0, ld_err}, 64'd0);

        for (int v = 0; v < 7; v++) begin
            fetch(vecs[v].en, vecs[v].addr);
            chk($sformatf("vec%0d_data", v), rd_data, vecs[v].data);
            chk($sformatf("vec%0d_valid", v), {60'd0, rd_valid}, {60'd0, vecs[v].valid});
            chk($sformatf("vec%0d_oob", v), {60'd0, rd_oob & rd_valid}, {60'd0, vecs[v].oobm});
        end

        // Read-before-write on the host port.
        im_write_en = 1'b1; im_addr = 16'd2; im_input_data = 16'h0017;
        fetch(4'b0001, 64'd2);
        im_write_en = 1'b0;
        chk("rbw_old", {48'd0, rd_data[15:0]}, 64'h0007);
        fetch(4'b0001, 64'd2);
        chk("rbw_new", {48'd0, rd_data[15:0]}, 64'h0017);

        // Out-of-range host write must not alias onto address 0.
        im_write_en = 1'b1; im_addr = 16'd128; im_input_data = 16'h0099;
        tick();
        im_write_en = 1'b0;
        fetch(4'b0001, 64'd0);
        chk("oob_write_dropped", {48'd0, rd_data[15:0]}, 64'h0003);

        // Burst running off the end, with host writes attempted during LOAD.
        beat_data[0] = 16'h0011; beat_data[1] = 16'h0022;
        beat_data[2] = 16'h0033; beat_data[3] = 16'h0044;
        burst(16'd126, 16'd4, 1'b0, 1'b1);
        chk("edge_err", {63'd0, ld_err}, 64'd1);
        fetch(4'b1111, {16'd1, 16'd0, 16'd127, 16'd126});
        chk("edge_data", rd_data, {16'h0005, 16'h0003, 16'h0022, 16'h0011});

        // Gapped burst; ld_err clears on the new start.
        beat_data[0] = 16'h000A; beat_data[1] = 16'h000B; beat_data[2] = 16'h000C;
        burst(16'd10, 16'd3, 1'b1, 1'b0);
        chk("gap_err_clr", {63'd0, ld_err}, 64'd0);
        fetch(4'b1111, {16'd2, 16'd12, 16'd11, 16'd10});
        chk("gap_data", rd_data, {16'h0017, 16'h000C, 16'h000B, 16'h000A});

        // Zero-length burst writes nothing.
        burst(16'd0, 16'd0, 1'b0, 1'b0);
        fetch(4'b1111, {16'd10, 16'd2, 16'd1, 16'd0});
        chk("len0_data", rd_data, {16'h000A, 16'h0017, 16'h0005, 16'h0003});

        // Reset in the middle of a burst.
        ld_start = 1'b1; ld_base = 16'd20; ld_len = 16'd3;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 16'h0055;
        tick();
        ld_data = 16'h0056;
        #2;
        rst_n = 1'b0;
        #1;
        ld_valid = 1'b0;
        chk("mid_rst_flags", {60'd0, ld_ready, ld_done, ld_err, mem_ready}, 64'd0);
        chk("mid_rst_rd_data", rd_data, 64'd0);
        chk("mid_rst_rd_valid", {60'd0, rd_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fetch(4'b1111, 64'd0);
        chk("post_rst_valid", {60'd0, rd_valid}, 64'd0);
        chk("post_rst_mem_ready", {63'd0, mem_ready}, 64'd0);

        beat_data[0] = 16'h0061; beat_data[1] = 16'h0062; beat_data[2] = 16'h0063;
        burst(16'd20, 16'd3, 1'b0, 1'b0);
        fetch(4'b1111, {16'd10, 16'd22, 16'd21, 16'd20});
        chk("reload_data", rd_data, {16'h000A, 16'h0063, 16'h0062, 16'h0061});
        chk("reload_valid", {60'd0, rd_valid}, 64'hF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ins_memory_mp.md
Name: ins_memory_mp

Overview:
- Parametrised multi-port instruction memory for the N-core matrix-multiplication processor.
- Serves NUM_PORTS independent synchronous instruction fetch ports, one per core.
- Adds a burst program loader with a valid/ready handshake and a run-enable gate (mem_ready) that holds the cores until a program is loaded.
- Keeps the single-word direct write port (im_write_en/im_addr/im_input_data) for the host.

Parameters:
- NUM_PORTS, 4: number of core fetch ports (1..8).
- DATA_W, 16: instruction word width.
- ADDR_W, 16: address width on every port.
- DEPTH, 128: number of words. Valid addresses are 0..DEPTH-1, and DEPTH <= 2**ADDR_W.
- OOB_WORD, 16'd44: word returned for an out-of-range fetch (endop opcode).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_en  in  NUM_PORTS  per-port fetch request.
- rd_addr  in  NUM_PORTS*ADDR_W  flattened fetch addresses; port p uses bits [p*ADDR_W +: ADDR_W].
- rd_data  out  NUM_PORTS*DATA_W  flattened fetched words.
- rd_valid  out  NUM_PORTS  rd_data for that port is new this cycle.
- rd_oob  out  NUM_PORTS  the fetch on that port was out of range.
- im_write_en  in  1  direct single-word write strobe.
- im_addr  in  ADDR_W  direct write address.
- im_input_data  in  DATA_W  direct write data.
- ld_start  in  1  begin a burst load.
- ld_base  in  ADDR_W  first address of the burst.
- ld_len  in  ADDR_W  number of words in the burst.
- ld_valid  in  1  loader data beat is valid.
- ld_data  in  DATA_W  loader data.
- ld_ready  out  1  block accepts a loader beat.
- ld_done  out  1  one-cycle pulse when the burst completes.
- ld_err  out  1  sticky flag: a burst beat addressed beyond DEPTH-1.
- mem_ready  out  1  program is loaded; cores may fetch.

Behaviour:
- Reset values: rd_data=0, rd_valid=0, rd_oob=0, ld_ready=0, ld_done=0, ld_err=0, mem_ready=0, state=IDLE. Memory contents are not reset.
- Reset asserted mid-burst aborts the burst and returns to IDLE. Words already written are kept.
- State machine, IDLE / LOAD / DONE / RUN:
  - IDLE: on ld_start, latch ld_base into ptr and ld_len into cnt, clear ld_err, go to LOAD. If ld_len=0, go straight to DONE.
  - LOAD: ld_ready=1 (registered, asserted from the first LOAD cycle). Each cycle with ld_valid&&ld_ready writes mem[ptr]=ld_data, then ptr+1 and cnt-1. The beat that takes cnt to 0 moves to DONE. ld_start during LOAD is ignored.
  - DONE: ld_ready=0, ld_done=1 for exactly one cycle, then go to RUN.
  - RUN: mem_ready=1. ld_start returns to LOAD (or to DONE if ld_len=0), deasserts mem_ready and reloads.
- Burst beat with ptr > DEPTH-1: the write is dropped but the beat still counts; ld_err is set. ptr wraps modulo 2**ADDR_W.
- Fetch, 1-cycle latency, RUN state only:
  - rd_en[p] at edge n gives rd_data/rd_valid at edge n+1.
  - When rd_en[p]=0, or the state is not RUN: rd_valid[p]=0 and rd_data[p] holds its last value.
  - rd_addr[p] > DEPTH-1: rd_data[p]=OOB_WORD, rd_oob[p]=1, rd_valid[p]=1.
  - All ports read concurrently with no arbitration. Identical addresses on several ports return identical data.
- Direct write:
  - Accepted in IDLE and RUN. Ignored in LOAD and DONE.
  - Out-of-range im_addr is dropped silently.
  - Does not change state.
- Read/write same address in the same cycle (direct or burst): the read returns the OLD word (read-before-write). The new word is visible from the next fetch.
- Direct write and burst beat in the same cycle cannot happen, because direct writes are blocked in LOAD.

Decomposition:
- Shared package ins_mem_pkg:
  - state enum (IDLE, LOAD, DONE, RUN);
  - opcode constants, including ENDOP=44 and NOP=4, used by the OOB_WORD default and the benches.
- One natural sub-module, ins_mem_loader: the FSM, ptr/cnt, ld_ready/ld_done/ld_err and mem_ready. It drives the write enable, write address and write data into the storage array.
- Storage and the read ports stay in the top module.

Test Plan:
- Reset, then ld_start with base=0, len=3 and beats 0x0003, 0x0005, 0x0007 on consecutive cycles -> ld_ready high for 3 cycles, ld_done pulses once, mem_ready=1 on the next cycle. Fetch from addr 1 -> rd_data=0x0005 one cycle later, rd_valid=1.
- NUM_PORTS=4, all ports fetch 0, 1, 2, 0 in the same cycle -> rd_data = 0x0003, 0x0005, 0x0007, 0x0003, all rd_valid=1.
- In RUN, im_write_en to addr 2 with data 0x0017 while port0 fetches addr 2 -> old 0x0007 returned. The next fetch of addr 2 returns 0x0017.
- Fetch addr 200 with DEPTH=128 -> rd_data=0x002C, rd_oob=1. A burst with base=126, len=4 -> ld_err=1, only 126 and 127 written, ld_done still pulses.
- ld_valid stalls (gapped beats) and ld_len=0 -> a gapped burst completes after exactly len accepted beats. len=0 goes straight to DONE: ld_done pulses, no write occurs.
- rst_n low during LOAD after 1 of 3 beats -> all outputs at reset values, mem_ready=0, fetches give rd_valid=0. A reload then succeeds.
